// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and synchronous flush; optional stall counter under PIPE_SKID_PERF_EN.
// Latency 1 cycle from an accepted beat to out_valid; throughput 1 beat/cycle while out_ready is high.
// Backpressure: in_ready drops only when both entries are held, and is registered (no path from out_ready).
module pipe_skid_reg #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  perf_stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_ready;
  logic              r_out_valid;

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Handshake outputs are kept as registers alongside the state so that
  // neither one depends combinationally on the downstream ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_state     <= BUSY;
            r_main      <= in_data;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_state     <= FULL;
            r_skid      <= in_data;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end else if (w_out_fire) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            r_state     <= BUSY;
            r_main      <= r_skid;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_state;

`ifdef PIPE_SKID_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  assign w_stall = r_out_valid && !out_ready;

  // Saturating and deliberately blind to flush; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, async-reset sequence, and random traffic vs a queue model.
module tb_pipe_skid_reg;

  localparam int          DW  = 64;
  localparam int          CW  = 4;
  localparam logic [63:0] RV  = 64'h13;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] perf_stall_cnt;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .DATA_W   (DW),
    .RESET_VAL(RV),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .occupancy     (occupancy),
    .perf_stall_cnt(perf_stall_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a FIFO of held beats capped at two, plus the last value shown.
  logic [63:0] mq[$];
  logic [63:0] m_last;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = RV;
    m_cnt  = 0;
  endtask

  task automatic model_step();
    bit ifire, ofire;
    ifire = in_valid && (mq.size() < 2);
    ofire = (mq.size() > 0) && out_ready;
`ifdef PIPE_SKID_PERF_EN
    if ((mq.size() > 0) && !out_ready && (m_cnt < CNT_MAX)) m_cnt++;
`endif
    if (flush) begin
      mq.delete();
      m_last = RV;
    end else begin
      if (ofire) m_last = mq.pop_front();
      if (ifire) mq.push_back(in_data);
    end
  endtask

  task automatic check_model(input string tag);
    logic [63:0] exp_d;
    exp_d = (mq.size() > 0) ? mq[0] : m_last;
    check({tag, ".occ"},   64'(occupancy),      64'(mq.size()));
    check({tag, ".ovld"},  64'(out_valid),      64'(mq.size() > 0));
    check({tag, ".irdy"},  64'(in_ready),       64'(mq.size() < 2));
    check({tag, ".data"},  out_data,            exp_d);
    check({tag, ".perf"},  64'(perf_stall_cnt), 64'(m_cnt));
  endtask

  // Drive inputs (called just after a falling edge), advance one rising edge, return at the next falling edge.
  task automatic cycle(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic        fl;
    logic        e_ovld;
    logic        e_irdy;
    logic [1:0]  e_occ;
    logic [63:0] e_data;
  } vec_t;

  vec_t vt[12];

  initial begin
    // Push A,B,C with out_ready=1, then drain.
    vt[0]  = '{1'b1, 64'hA, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'hA};
    vt[1]  = '{1'b1, 64'hB, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'hB};
    vt[2]  = '{1'b1, 64'hC, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'hC};
    vt[3]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 64'hC};
    // Fill with 1,2 under backpressure, then release in order.
    vt[4]  = '{1'b1, 64'h1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'h1};
    vt[5]  = '{1'b1, 64'h2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'h1};
    vt[6]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h2};
    vt[7]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 64'h2};
    // Fill with 5,6, flush while 7 is offered; 7 must never show up.
    vt[8]  = '{1'b1, 64'h5, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'h5};
    vt[9]  = '{1'b1, 64'h6, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'h5};
    vt[10] = '{1'b1, 64'h7, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, RV};
    vt[11] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, RV};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check("rst.irdy", 64'(in_ready),       64'd1);
    check("rst.ovld", 64'(out_valid),      64'd0);
    check("rst.occ",  64'(occupancy),      64'd0);
    check("rst.data", out_data,            RV);
    check("rst.perf", 64'(perf_stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(vt[i].iv, vt[i].d, vt[i].ordy, vt[i].fl);
      check({tag, ".ovld"}, 64'(out_valid), 64'(vt[i].e_ovld));
      check({tag, ".irdy"}, 64'(in_ready),  64'(vt[i].e_irdy));
      check({tag, ".occ"},  64'(occupancy), 64'(vt[i].e_occ));
      check({tag, ".data"}, out_data,       vt[i].e_data);
      check({tag, ".perf"}, 64'(perf_stall_cnt), 64'(m_cnt));
    end

    // Stall counter saturation: hold one beat with out_ready low for 20 cycles.
    cycle(1'b1, 64'h42, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 64'h0, 1'b0, 1'b0);
`ifdef PIPE_SKID_PERF_EN
    check("perf.sat", 64'(perf_stall_cnt), 64'd15);
`else
    check("perf.off", 64'(perf_stall_cnt), 64'd0);
`endif
    check("perf.data", out_data, 64'h42);

    // Async reset while FULL must clear handshake before the next rising edge.
    cycle(1'b1, 64'h43, 1'b0, 1'b0);
    check("full.occ", 64'(occupancy), 64'd2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst.ovld", 64'(out_valid),      64'd0);
    check("arst.irdy", 64'(in_ready),       64'd1);
    check("arst.occ",  64'(occupancy),      64'd0);
    check("arst.data", out_data,            RV);
    check("arst.perf", 64'(perf_stall_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic        iv, ordy, fl;
      logic [63:0] d;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      d    = {$urandom, $urandom};
      cycle(iv, d, ordy, fl);
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
